pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: stallreq_if, stallreq_id, stallreq_ex, stallreq_mem  in  1 each  stage stall requests; stallreq_ex is held by the multi-cycle divider, stallreq_mem by the bus wait.
REQ-004 SHALL have ports: ex_is_load  in  1, ex_wreg  in  1, ex_wd  in  5  describe the load instruction currently in EX.
REQ-005 SHALL have ports: id_rs, id_rt  in  5 each; id_rs_read, id_rt_read  in  1 each  ID source registers and their read enables.
REQ-006 SHALL have ports: excp_req  in  1, excp_vec  in  32  exception request from MEM and its handler address.
REQ-007 SHALL have port: stall  out  6  freeze vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-008 SHALL have ports: flush  out  1, new_pc_valid  out  1, new_pc  out  32  flush and redirect controls.
REQ-009 SHALL have port: stall_cnt  out  32  count of cycles with stall[0]=1.

Function
REQ-010 SHALL compute load_use = ex_is_load & ex_wreg & (ex_wd!=0) & ((id_rs_read & id_rs==ex_wd) | (id_rt_read & id_rt==ex_wd)), combinationally.
REQ-011 SHALL drive stall combinationally in RUN state, highest stage first: stallreq_mem -> 011111; else stallreq_ex -> 001111; else stallreq_id|load_use -> 000111; else stallreq_if -> 000011; else 000000.
REQ-012 SHALL never assert stall[5]; WB always retires.
REQ-013 SHALL implement FSM states RUN, FLUSH, REDIRECT.
REQ-014 RUN -> FLUSH when excp_req=1 and stallreq_mem=0; excp_vec latched into new_pc on that edge.
REQ-015 SHALL hold RUN (no exception accepted) while stallreq_mem=1, even if excp_req=1.
REQ-016 FLUSH: flush=1 for exactly one cycle, stall=000000; next state REDIRECT unconditionally.
REQ-017 REDIRECT: new_pc_valid=1 for exactly one cycle with the latched new_pc, stall=000000; next state RUN.
REQ-018 SHALL ignore excp_req and all stall requests in FLUSH and REDIRECT; the exception-to-redirect latency SHALL be 2 cycles (flush in cycle N+1, new_pc_valid in cycle N+2 after request in cycle N).
REQ-019 flush and new_pc_valid SHALL be decoded from state only (registered, glitch-free).
REQ-020 new_pc SHALL hold its last latched value outside REDIRECT.
REQ-021 stall_cnt SHALL increment by 1 each cycle stall[0]=1, saturating at 0xFFFFFFFF (no wrap).

Reset
REQ-022 On rst=1 at a rising edge: state=RUN, new_pc=0, stall_cnt=0; flush=0, new_pc_valid=0 from the next cycle.
REQ-023 While rst=1, stall SHALL be forced to 000000 and excp_req ignored.
REQ-024 Reset mid-FLUSH or mid-REDIRECT SHALL abort the sequence; no new_pc_valid pulse follows.

Structure
REQ-025 Stall bit indices, stall vector constants and FSM state encodings SHALL live in defines.v.
REQ-026 Load-use comparison SHALL be a sub-module hazard_detect (purely combinational, outputs load_use).
REQ-027 SHALL contain no latches; one always block for the FSM, one for stall_cnt.

Verification
REQ-028 Load-use: ex_is_load=1, ex_wreg=1, ex_wd=5, id_rs=5, id_rs_read=1 -> stall=000111; with ex_wd=0 -> stall=000000.
REQ-029 Priority: stallreq_if=stallreq_ex=stallreq_mem=1 -> 011111; drop mem -> 001111; drop ex -> 000011.
REQ-030 Exception: excp_req=1, excp_vec=0x00000020 in cycle N -> flush=1 in N+1, new_pc_valid=1 with new_pc=0x00000020 in N+2, both 0 in N+3.
REQ-031 Exception during mem stall: excp_req=1 with stallreq_mem=1 for 3 cycles -> no flush; flush one cycle after stallreq_mem falls.
REQ-032 Counter: stallreq_if held 10 cycles -> stall_cnt=10; preload to 0xFFFFFFFE, stall 3 cycles -> 0xFFFFFFFF.
REQ-033 Reset in FLUSH cycle -> flush=0 and new_pc_valid=0 next cycle, stall_cnt=0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - stall vector layout, stall constants and FSM encoding for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // Each requester freezes its own stage and everything upstream of it.
  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_FROM_IF  = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_FROM_ID  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_FROM_EX  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_FROM_MEM = 6'b011111;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard detection between EX and ID
module hazard_detect (
  input  logic       ex_is_load,
  input  logic       ex_wreg,
  input  logic [4:0] ex_wd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_read,
  input  logic       id_rt_read,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_rs_read && (id_rs == ex_wd);
  assign rt_hit   = id_rt_read && (id_rt == ex_wd);
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load && ex_wreg && (ex_wd != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with exception redirect and stall counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               ex_is_load,
  input  logic               ex_wreg,
  input  logic [4:0]         ex_wd,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_read,
  input  logic               id_rt_read,
  input  logic               excp_req,
  input  logic [31:0]        excp_vec,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               new_pc_valid,
  output logic [31:0]        new_pc,
  output logic [31:0]        stall_cnt
);

  state_t      state;
  state_t      state_nxt;
  logic        load_use;
  logic        excp_take;
  logic [31:0] new_pc_q;
  logic [31:0] stall_cnt_q;

  hazard_detect u_hazard_detect (
    .ex_is_load (ex_is_load),
    .ex_wreg    (ex_wreg),
    .ex_wd      (ex_wd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_read (id_rs_read),
    .id_rt_read (id_rt_read),
    .load_use   (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      new_pc_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (excp_take) begin
        new_pc_q <= excp_vec;
      end
    end
  end

  // A pending bus wait blocks exception entry so MEM never flushes mid-access.
  always_comb begin
    state_nxt = state;
    stall     = STALL_NONE;
    excp_take = 1'b0;
    case (state)
      ST_RUN: begin
        if (stallreq_mem) begin
          stall = STALL_FROM_MEM;
        end else if (stallreq_ex) begin
          stall = STALL_FROM_EX;
        end else if (stallreq_id || load_use) begin
          stall = STALL_FROM_ID;
        end else if (stallreq_if) begin
          stall = STALL_FROM_IF;
        end
        if (excp_req && !stallreq_mem) begin
          excp_take = 1'b1;
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH:    state_nxt = ST_REDIRECT;
      ST_REDIRECT: state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
    if (rst) begin
      stall     = STALL_NONE;
      excp_take = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (stall[STALL_PC] && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign flush        = (state == ST_FLUSH);
  assign new_pc_valid = (state == ST_REDIRECT);
  assign new_pc       = new_pc_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - table, directed and randomized checks of pipe_ctrl against a cycle model
module tb_pipe_ctrl;

  typedef struct {
    logic        rst;
    logic [3:0]  sreq;     // {mem, ex, id, if}
    logic        ld;
    logic        wreg;
    logic [4:0]  wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_rd;
    logic        rt_rd;
    logic        excp;
    logic [31:0] vec;
  } in_t;

  typedef struct {
    in_t        i;
    logic [5:0] exp_stall;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        ex_is_load, ex_wreg;
  logic [4:0]  ex_wd, id_rs, id_rt;
  logic        id_rs_read, id_rt_read;
  logic        excp_req;
  logic [31:0] excp_vec;
  logic [5:0]  stall;
  logic        flush, new_pc_valid;
  logic [31:0] new_pc, stall_cnt;

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0 = running, 1 = flush cycle, 2 = redirect cycle
  int          phase = 0;
  logic [31:0] m_pc = 0;
  longint      m_cnt = 0;

  logic [5:0]  s_stall;
  logic        s_flush, s_npv;
  logic [31:0] s_pc, s_cnt;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .ex_is_load   (ex_is_load),
    .ex_wreg      (ex_wreg),
    .ex_wd        (ex_wd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_read   (id_rs_read),
    .id_rt_read   (id_rt_read),
    .excp_req     (excp_req),
    .excp_vec     (excp_vec),
    .stall        (stall),
    .flush        (flush),
    .new_pc_valid (new_pc_valid),
    .new_pc       (new_pc),
    .stall_cnt    (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic in_t idle();
    in_t v;
    v.rst = 0; v.sreq = 0; v.ld = 0; v.wreg = 0; v.wd = 0; v.rs = 0; v.rt = 0;
    v.rs_rd = 0; v.rt_rd = 0; v.excp = 0; v.vec = 0;
    return v;
  endfunction

  function automatic in_t mk_sreq(logic [3:0] s);
    in_t v = idle();
    v.sreq = s;
    return v;
  endfunction

  function automatic in_t mk_excp(logic [31:0] vec, logic mem);
    in_t v = idle();
    v.excp = 1; v.vec = vec; v.sreq = {mem, 3'b000};
    return v;
  endfunction

  function automatic in_t mk_ld(logic wreg, logic [4:0] wd, logic [4:0] rs, logic rs_rd,
                                logic [4:0] rt, logic rt_rd, logic [3:0] s);
    in_t v = idle();
    v.ld = 1; v.wreg = wreg; v.wd = wd; v.rs = rs; v.rs_rd = rs_rd;
    v.rt = rt; v.rt_rd = rt_rd; v.sreq = s;
    return v;
  endfunction

  // Freeze depth = one more than the index of the deepest requesting stage.
  function automatic logic [5:0] m_stall(in_t v);
    int  top = 0;
    bit  lu;
    if (v.rst || phase != 0) return 6'd0;
    lu = v.ld && v.wreg && v.wd != 0 &&
         ((v.rs_rd && v.rs == v.wd) || (v.rt_rd && v.rt == v.wd));
    if (v.sreq[0]) top = 1;
    if (v.sreq[1] || lu) top = 2;
    if (v.sreq[2]) top = 3;
    if (v.sreq[3]) top = 4;
    if (top == 0) return 6'd0;
    return 6'((1 << (top + 1)) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    rst = v.rst;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = v.sreq;
    ex_is_load = v.ld; ex_wreg = v.wreg; ex_wd = v.wd;
    id_rs = v.rs; id_rt = v.rt; id_rs_read = v.rs_rd; id_rt_read = v.rt_rd;
    excp_req = v.excp; excp_vec = v.vec;
  endtask

  task automatic step(input in_t v);
    logic [5:0] es;
    @(negedge clk);
    apply(v);
    #1;
    es = m_stall(v);
    s_stall = stall; s_flush = flush; s_npv = new_pc_valid; s_pc = new_pc; s_cnt = stall_cnt;
    check("stall", {26'd0, stall}, {26'd0, es});
    check("flush", {31'd0, flush}, {31'd0, phase == 1});
    check("new_pc_valid", {31'd0, new_pc_valid}, {31'd0, phase == 2});
    check("new_pc", new_pc, m_pc);
    check("stall_cnt", stall_cnt, m_cnt[31:0]);
    @(posedge clk);
    n_vec++;
    if (v.rst) begin
      phase = 0; m_pc = 0; m_cnt = 0;
    end else begin
      if (es[0] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (phase == 0 && v.excp && !v.sreq[3]) begin
        phase = 1; m_pc = v.vec;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2) begin
        phase = 0;
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    in_t r;
    r = idle();
    r.rst = 1;
    @(negedge clk);
    apply(r);
    @(posedge clk);

    // reset state
    step(r);
    step(idle());
    check("rst_stall", {26'd0, s_stall}, 32'd0);
    check("rst_cnt", s_cnt, 32'd0);
    check("rst_pc", s_pc, 32'd0);

    // stall priority and load-use table
    tbl.push_back('{mk_ld(1, 5, 5, 1, 0, 0, 4'b0000), 6'b000111});
    tbl.push_back('{mk_ld(1, 0, 0, 1, 0, 0, 4'b0000), 6'b000000});
    tbl.push_back('{mk_ld(1, 7, 1, 1, 7, 1, 4'b0000), 6'b000111});
    tbl.push_back('{mk_ld(1, 7, 1, 1, 7, 0, 4'b0000), 6'b000000});
    tbl.push_back('{mk_ld(0, 5, 5, 1, 0, 0, 4'b0000), 6'b000000});
    tbl.push_back('{mk_ld(1, 5, 5, 0, 5, 0, 4'b0000), 6'b000000});
    tbl.push_back('{mk_sreq(4'b1101), 6'b011111});
    tbl.push_back('{mk_sreq(4'b0101), 6'b001111});
    tbl.push_back('{mk_sreq(4'b0001), 6'b000011});
    tbl.push_back('{mk_sreq(4'b0010), 6'b000111});
    tbl.push_back('{mk_sreq(4'b0011), 6'b000111});
    tbl.push_back('{mk_ld(1, 3, 3, 1, 0, 0, 4'b1000), 6'b011111});
    tbl.push_back('{mk_ld(1, 3, 3, 1, 0, 0, 4'b0001), 6'b000111});
    tbl.push_back('{mk_sreq(4'b0000), 6'b000000});
    foreach (tbl[k]) begin
      step(tbl[k].i);
      check($sformatf("tbl%0d_stall", k), {26'd0, s_stall}, {26'd0, tbl[k].exp_stall});
    end

    // exception: flush in N+1, redirect in N+2, quiet in N+3
    step(mk_excp(32'h0000_0020, 0));
    check("exc_n_flush", {31'd0, s_flush}, 32'd0);
    r = mk_excp(32'h0000_0099, 0);
    r.sreq = 4'b1111;
    step(r);
    check("exc_n1_flush", {31'd0, s_flush}, 32'd1);
    check("exc_n1_stall", {26'd0, s_stall}, 32'd0);
    step(mk_sreq(4'b0111));
    check("exc_n2_valid", {31'd0, s_npv}, 32'd1);
    check("exc_n2_pc", s_pc, 32'h0000_0020);
    check("exc_n2_stall", {26'd0, s_stall}, 32'd0);
    step(idle());
    check("exc_n3_flush", {31'd0, s_flush}, 32'd0);
    check("exc_n3_valid", {31'd0, s_npv}, 32'd0);
    check("exc_n3_pc", s_pc, 32'h0000_0020);

    // exception held off by bus wait
    for (int k = 0; k < 3; k++) begin
      step(mk_excp(32'h0000_0040, 1));
      check("memwait_flush", {31'd0, s_flush}, 32'd0);
    end
    step(mk_excp(32'h0000_0040, 0));
    check("memwait_fall_flush", {31'd0, s_flush}, 32'd0);
    step(idle());
    check("memwait_flush_after", {31'd0, s_flush}, 32'd1);
    step(idle());
    check("memwait_pc", s_pc, 32'h0000_0040);
    step(idle());

    // stall counter and saturation
    r = idle(); r.rst = 1;
    step(r);
    for (int k = 0; k < 10; k++) step(mk_sreq(4'b0001));
    step(idle());
    check("cnt_10", s_cnt, 32'd10);
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 64'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) step(mk_sreq(4'b0100));
    step(idle());
    check("cnt_sat", s_cnt, 32'hFFFF_FFFF);

    // reset during flush aborts the redirect
    step(mk_excp(32'h0000_0080, 0));
    r = idle(); r.rst = 1; r.sreq = 4'b1111;
    step(r);
    check("rstfl_flush_in", {31'd0, s_flush}, 32'd1);
    check("rstfl_stall", {26'd0, s_stall}, 32'd0);
    step(idle());
    check("rstfl_flush", {31'd0, s_flush}, 32'd0);
    check("rstfl_valid", {31'd0, s_npv}, 32'd0);
    check("rstfl_cnt", s_cnt, 32'd0);
    check("rstfl_pc", s_pc, 32'd0);
    step(idle());
    check("rstfl_valid2", {31'd0, s_npv}, 32'd0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      r.rst   = ($urandom_range(0, 31) == 0);
      r.sreq  = 4'($urandom) & 4'($urandom);
      r.ld    = 1'($urandom);
      r.wreg  = 1'($urandom);
      r.wd    = 5'($urandom_range(0, 3));
      r.rs    = 5'($urandom_range(0, 3));
      r.rt    = 5'($urandom_range(0, 3));
      r.rs_rd = 1'($urandom);
      r.rt_rd = 1'($urandom);
      r.excp  = ($urandom_range(0, 5) == 0);
      r.vec   = $urandom;
      step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
